// File: rtl/gpio_cfg_shift_ctrl_if.sv
// ----------------------------------------------------------------------------
// gpio_cfg_shift_ctrl_if
// Serial configuration bus for the GPIO pad controller chain.
//   serial_data_in   : configuration bit, MSB first
//   serial_shift     : shift strobe, one bit per cycle while high
//   serial_load      : single-cycle pulse, commit shift register to config
//   serial_data_out  : shift[12], daisy-chain output
//   load_ok/load_err : single-cycle status of the last load pulse
// master = configuration source, slave = pad controller.
// ----------------------------------------------------------------------------
interface gpio_cfg_shift_ctrl_if;
    logic serial_data_in;
    logic serial_shift;
    logic serial_load;
    logic serial_data_out;
    logic load_ok;
    logic load_err;

    modport master (
        output serial_data_in,
        output serial_shift,
        output serial_load,
        input  serial_data_out,
        input  load_ok,
        input  load_err
    );

    modport slave (
        input  serial_data_in,
        input  serial_shift,
        input  serial_load,
        output serial_data_out,
        output load_ok,
        output load_err
    );
endinterface

// File: rtl/gpio_cfg_shift_ctrl.sv
// ----------------------------------------------------------------------------
// gpio_cfg_shift_ctrl
// Per-pad GPIO controller with a 13-bit serially loaded configuration.
// A load is accepted only when exactly 13 bits were shifted since the last
// load or reset; otherwise it is rejected and the active config is kept.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   ser                : serial config bus (slave side)
//   mgmt_gpio_out/oeb  : management-side output data / active-low enable
//   user_gpio_out/oeb  : user-side output data / active-low enable
//   mgmt_gpio_in       : synchronized pad input to management side
//   user_gpio_in       : synchronized pad input to user side
//   pad_in             : raw pad input, asynchronous to clk
//   pad_*              : pad control outputs decoded from the config
//
// Config bit map
//   [0] mgmt_ena  [1] oe_ovr  [2] hld_ovr  [3] inp_dis  [4] ib_mode_sel
//   [5] analog_en [6] analog_sel [7] analog_pol [8] slow [9] vtrip_sel
//   [12:10] dm
// ----------------------------------------------------------------------------
module gpio_cfg_shift_ctrl #(
    parameter logic [12:0] CFG_INIT = 13'h0403
) (
    input  logic       clk,
    input  logic       reset,
    gpio_cfg_shift_ctrl_if.slave ser,

    input  logic       mgmt_gpio_out,
    input  logic       mgmt_gpio_oeb,
    input  logic       user_gpio_out,
    input  logic       user_gpio_oeb,
    output logic       mgmt_gpio_in,
    output logic       user_gpio_in,

    input  logic       pad_in,
    output logic       pad_out,
    output logic       pad_oe_n,
    output logic       pad_hld_ovr,
    output logic       pad_inp_dis,
    output logic       pad_ib_mode_sel,
    output logic       pad_analog_en,
    output logic       pad_analog_sel,
    output logic       pad_analog_pol,
    output logic       pad_slow,
    output logic       pad_vtrip_sel,
    output logic [2:0] pad_dm
);

    localparam logic [3:0] CNT_FULL = 4'd13;
    localparam logic [3:0] CNT_MAX  = 4'd15;

    logic [12:0] shift_q, shift_d;
    logic [12:0] cfg_q,   cfg_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        load_ok_q,  load_ok_d;
    logic        load_err_q, load_err_d;
    logic        sync1_q, sync2_q;
    logic        pin_sync;

    // Load wins over shift: the committed word is the pre-edge shift
    // register and that cycle's shift bit is dropped.
    always_comb begin
        shift_d    = shift_q;
        cfg_d      = cfg_q;
        cnt_d      = cnt_q;
        load_ok_d  = 1'b0;
        load_err_d = 1'b0;
        if (ser.serial_load) begin
            cnt_d = 4'd0;
            if (cnt_q == CNT_FULL) begin
                cfg_d     = shift_q;
                load_ok_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (ser.serial_shift) begin
            shift_d = {shift_q[11:0], ser.serial_data_in};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            cfg_q      <= CFG_INIT;
            cnt_q      <= '0;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            load_ok_q  <= load_ok_d;
            load_err_q <= load_err_d;
            sync1_q    <= pad_in;
            sync2_q    <= sync1_q;
        end
    end

    assign pin_sync = sync2_q;

    assign ser.serial_data_out = shift_q[12];
    assign ser.load_ok         = load_ok_q;
    assign ser.load_err        = load_err_q;

    assign pad_out         = cfg_q[0] ? mgmt_gpio_out : user_gpio_out;
    // Output-enable override forces the driver off regardless of owner.
    assign pad_oe_n        = cfg_q[1] | (cfg_q[0] ? mgmt_gpio_oeb : user_gpio_oeb);
    assign pad_hld_ovr     = cfg_q[2];
    assign pad_inp_dis     = cfg_q[3];
    assign pad_ib_mode_sel = cfg_q[4];
    assign pad_analog_en   = cfg_q[5];
    assign pad_analog_sel  = cfg_q[6];
    assign pad_analog_pol  = cfg_q[7];
    assign pad_slow        = cfg_q[8];
    assign pad_vtrip_sel   = cfg_q[9];
    assign pad_dm          = cfg_q[12:10];

    assign mgmt_gpio_in = pin_sync &  cfg_q[0] & ~cfg_q[3];
    assign user_gpio_in = pin_sync & ~cfg_q[0] & ~cfg_q[3];

endmodule
